// File: rtl/alu_pkg.sv
// Shared ALU opcodes and the multiplier sequencer state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_OP_AND = 3'b000;
  localparam logic [2:0] ALU_OP_OR  = 3'b001;
  localparam logic [2:0] ALU_OP_ADD = 3'b010;
  localparam logic [2:0] ALU_OP_SLT = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/alu_16bitt.sv
// 16-bit ripple-carry ALU: AND, OR, ADD/SUB (via ainvert/bnegate/cin) and SLT.
module alu_16bitt
  import alu_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [2:0]  op,
  input  logic        ainvert,
  input  logic        bnegate,
  input  logic        cin,
  output logic [15:0] result,
  output logic        cout,
  output logic        zero,
  output logic        overflow
);

  logic [15:0] a_eff;
  logic [15:0] b_eff;
  logic [15:0] sum_bits;
  logic [16:0] carry;
  logic [15:0] slt_bits;
  logic        set_less;

  // Single block keeps the carry chain statically ordered.
  always_comb begin
    carry[0] = cin;
    sum_bits = '0;
    for (int i = 0; i < 16; i++) begin
      sum_bits[i]  = a_eff[i] ^ b_eff[i] ^ carry[i];
      carry[i + 1] = (a_eff[i] & b_eff[i]) | (carry[i] & (a_eff[i] ^ b_eff[i]));
    end
  end

  assign overflow = carry[16] ^ carry[15];
  assign cout     = carry[16];
  assign set_less = sum_bits[15] ^ overflow;
  assign slt_bits = {15'd0, set_less};

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_slice
      assign a_eff[gi]  = a[gi] ^ ainvert;
      assign b_eff[gi]  = b[gi] ^ bnegate;
      assign result[gi] = (op == ALU_OP_AND) ? (a_eff[gi] & b_eff[gi]) :
                          (op == ALU_OP_OR)  ? (a_eff[gi] | b_eff[gi]) :
                          (op == ALU_OP_ADD) ? sum_bits[gi] :
                          (op == ALU_OP_SLT) ? slt_bits[gi] : 1'b0;
    end
  endgenerate

  assign zero = ~|result;

endmodule

// File: rtl/mult_seq16.sv
// Sequential 16x16 unsigned shift-add multiplier; one ALU add per iteration,
// 16 iterations, product = {acc_hi, acc_lo}.
module mult_seq16
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam logic [4:0] CNT_LAST = 5'(WIDTH - 1);

  mult_state_t      state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [4:0]       cnt;

  logic [WIDTH-1:0] alu_result;
  logic             alu_cout;
  logic             unused_zero;
  logic             unused_overflow;
  logic [WIDTH:0]   sum;

  alu_16bitt u_alu (
    .a        (acc_hi),
    .b        (mcand),
    .op       (ALU_OP_ADD),
    .ainvert  (1'b0),
    .bnegate  (1'b0),
    .cin      (1'b0),
    .result   (alu_result),
    .cout     (alu_cout),
    .zero     (unused_zero),
    .overflow (unused_overflow)
  );

  // Carry is kept as bit 16 so the partial product never loses a bit.
  assign sum     = acc_lo[0] ? {alu_cout, alu_result} : {1'b0, acc_hi};
  assign product = {acc_hi, acc_lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= multiplicand;
            acc_hi <= '0;
            acc_lo <= multiplier;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          {acc_hi, acc_lo} <= {sum, acc_lo[WIDTH-1:1]};
          cnt <= cnt + 5'd1;
          if (cnt == CNT_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
